pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Two-requester arbiter that shares the single physical-memory port (`pmem_*`, 128-bit line, 16-bit address) between the instruction cache and the data cache. It sits between the split L1 caches inside `mp3` and `physical_memory`. It grants one whole transaction at a time and forwards `resp` and `rdata` only to the granted cache. Simultaneous requests are resolved round-robin.

## Interface
- `ADDR_W`, default 16: line address width.
- `LINE_W`, default 128: line data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  I-cache line read request, held until `i_resp`.
- `i_address`  in  ADDR_W  I-cache line address.
- `i_rdata`  out  LINE_W  line data returned to the I-cache.
- `i_resp`  out  1  I-cache transaction done.
- `d_read`  in  1  D-cache line read request, held until `d_resp`.
- `d_write`  in  1  D-cache writeback request, held until `d_resp`.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  D-cache writeback data.
- `d_rdata`  out  LINE_W  line data returned to the D-cache.
- `d_resp`  out  1  D-cache transaction done.
- `pmem_read`, `pmem_write`  out  1  memory strobes.
- `pmem_address`  out  ADDR_W  memory line address.
- `pmem_wdata`  out  LINE_W  memory write data.
- `pmem_rdata`  in  LINE_W  memory read data.
- `pmem_resp`  in  1  memory transaction done.
- `grant`  out  2  current owner: 00 none, 01 I-cache, 10 D-cache.

## Operation
- FSM states are IDLE, SERVE_I and SERVE_D. The state register and the round-robin pointer `last` (last served requester) are the only flops.
- IDLE transitions:
  - Only I requesting (`i_read`): go to SERVE_I.
  - Only D requesting (`d_read|d_write`): go to SERVE_D.
  - Both requesting: serve the requester ≠ `last`.
  - No request: stay in IDLE.
- SERVE_x:
  - `pmem_read`, `pmem_write` and `pmem_address` are driven combinationally from the granted requester's inputs. For I, `pmem_write`=0.
  - `pmem_wdata` always mirrors `d_wdata`.
  - On `pmem_resp`=1, `x_resp`=1 in the same cycle. Next state is IDLE and `last`←x.
  - With no `pmem_resp`, the FSM stays in SERVE_x. There is no timeout.
- Non-granted requester: `resp`=0. Its requests stay pending and are not dropped.
- `i_rdata`=`d_rdata`=`pmem_rdata` unconditionally. Data is valid only with the matching `resp`.
- A requester withdrawing its strobe mid-grant is a protocol violation. The arbiter still waits for `pmem_resp`; a bench assertion flags it.
- `d_read` and `d_write` high together is illegal; a bench assertion flags it. If it occurs, both are forwarded unchanged.
- Reset (any time, including mid-transaction):
  - State → IDLE, `last`←D, so I wins the first tie.
  - All `pmem_*` strobes, `i_resp`, `d_resp` and `grant` go to 0 immediately (asynchronously).
  - A memory transaction in flight is abandoned; memory must be reset alongside.

## Timing
- Grant latency: a request sampled in IDLE at edge k is driven on `pmem_*` in cycle k+1.
- Completion: `x_resp` is concurrent with `pmem_resp` (zero added cycles). `grant` returns to 00 on the next edge.
- There is a mandatory single IDLE cycle between transactions. It guarantees the completing requester has dropped its strobe before re-arbitration. Back-to-back throughput is memory latency + 2 cycles.
- A request arriving during SERVE_x is arbitrated in the first IDLE cycle after completion.
- Starvation bound: each requester waits at most one foreign transaction once asserted.

## Structure
- Package `pmem_arb_pkg` holds:
  - `arb_state_t` enum (IDLE, SERVE_I, SERVE_D).
  - `req_id_t` enum (REQ_I, REQ_D).
  - Default `ADDR_W`/`LINE_W` constants shared with the caches and `physical_memory`.
- No sub-module. The FSM, pointer and output mux are a single module.
- `mp3` instantiates it between the caches and its `pmem_*` ports. `mp3_tb` is unchanged.

## Test plan
- Reset, then `i_read`=1, `i_address`=16'h0040: `pmem_read`=1 with `pmem_address`=16'h0040 one cycle later. `i_resp` pulses with `pmem_resp`, `i_rdata`=memory line, `grant` goes 01 then 00.
- `d_write`=1, `d_address`=16'h1230, `d_wdata`=128'hDEAD…BEEF: `pmem_write`=1 and `pmem_wdata` match. `d_resp` pulses. A subsequent I read of 16'h1230 returns 128'hDEAD…BEEF.
- `i_read` and `d_read` asserted in the same cycle after reset: I is served first, D second. No `d_resp` during the I grant, and exactly one IDLE cycle between the grants.
- Both requesters re-request continuously for 6 transactions: grants alternate I, D, I, D, I, D. Neither is served twice in a row.
- `d_read` arrives mid-I-transaction: D stays pending and is granted on the cycle after the IDLE following `i_resp`. `d_address` is unchanged on `pmem_address`.
- `rst_n` pulsed low during SERVE_D: `pmem_read`/`pmem_write`/`grant` drop to 0 in the same cycle without waiting for `clk`. After release, an I request is granted first.

Source files
------------

// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the I/D-cache physical-memory arbiter.
package pmem_arb_pkg;

    localparam int unsigned PmemAddrW = 16;
    localparam int unsigned PmemLineW = 128;

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } arb_state_t;

    typedef enum logic {
        ReqI,
        ReqD
    } req_id_t;

    // Owner encoding seen on the grant port: 00 none, 01 I-cache, 10 D-cache.
    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            StServeI: return 2'b01;
            StServeD: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// One whole transaction is granted at a time; responses go only to the current owner.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = PmemAddrW,
    parameter int unsigned LINE_W = PmemLineW
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [1:0]        grant
);

    arb_state_t state_q, state_d;
    req_id_t    last_q, last_d;

    logic i_req;
    logic d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // last resets to D so the I-cache wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= ReqD;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_req && d_req) begin
                    state_d = (last_q == ReqI) ? StServeD : StServeI;
                end else if (i_req) begin
                    state_d = StServeI;
                end else if (d_req) begin
                    state_d = StServeD;
                end
            end
            StServeI: begin
                pmem_read    = i_read;
                pmem_address = i_address;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = StIdle;
                    last_d  = ReqI;
                end
            end
            StServeD: begin
                pmem_read    = d_read;
                pmem_write   = d_write;
                pmem_address = d_address;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = StIdle;
                    last_d  = ReqD;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign grant      = grant_of(state_q);
    assign pmem_wdata = d_wdata;
    // Data is broadcast; only the matching resp qualifies it.
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized and directed bench for pmem_arbiter with a behavioural memory and owner model.
module tb_pmem_arbiter;
    import pmem_arb_pkg::*;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_address, d_address, pmem_address;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
    logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
    logic [1:0]    grant;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference: owner 0 none / 1 I / 2 D, last served requester.
    int m_owner, m_last;
    bit pi, pd, presp;

    bit i_done, d_done;
    bit auto_i, auto_d;
    int prob_i, prob_d;
    int i_wait, d_wait;
    int served_q[$];
    logic [LW-1:0] last_i_data;

    // Physical memory contents and the requesters' own view of them.
    logic [LW-1:0] mem     [logic [AW-1:0]];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];
    bit mbusy, mem_hold;
    int mlat;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        return AW'($urandom_range(0, 7) * 16);
    endfunction

    function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : {8{a}};
    endfunction

    function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : {8{a}};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (grant == 2'b01 && !i_read) $error("protocol: i_read withdrawn while granted");
            if (grant == 2'b10 && !(d_read || d_write))
                $error("protocol: D strobe withdrawn while granted");
            if (d_read && d_write) $error("protocol: d_read and d_write together");
        end
    end

    task automatic step();
        pi    = i_read;
        pd    = d_read | d_write;
        presp = pmem_resp;
        @(posedge clk);
        #1;
        if (m_owner == 0) begin
            if (pi && pd)  m_owner = (m_last == 1) ? 2 : 1;
            else if (pi)   m_owner = 1;
            else if (pd)   m_owner = 2;
        end else if (presp) begin
            m_last  = m_owner;
            m_owner = 0;
        end

        if (i_done) i_read = 1'b0;
        if (d_done) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        i_done = 1'b0;
        d_done = 1'b0;
        if (auto_i && !i_read && $urandom_range(0, 99) < prob_i) begin
            i_read    = 1'b1;
            i_address = pick_addr();
        end
        if (auto_d && !d_read && !d_write && $urandom_range(0, 99) < prob_d) begin
            if ($urandom_range(0, 1) == 1) d_write = 1'b1;
            else d_read = 1'b1;
            d_address = pick_addr();
            d_wdata   = rand_line();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        #1;

        check("grant", LW'(grant), LW'(m_owner));
        case (m_owner)
            1: begin
                check("pmem_read_i", LW'(pmem_read), LW'(i_read));
                check("pmem_write_i", LW'(pmem_write), '0);
                check("pmem_addr_i", LW'(pmem_address), LW'(i_address));
            end
            2: begin
                check("pmem_read_d", LW'(pmem_read), LW'(d_read));
                check("pmem_write_d", LW'(pmem_write), LW'(d_write));
                check("pmem_addr_d", LW'(pmem_address), LW'(d_address));
            end
            default: begin
                check("pmem_read_idle", LW'(pmem_read), '0);
                check("pmem_write_idle", LW'(pmem_write), '0);
            end
        endcase
        check("pmem_wdata", pmem_wdata, d_wdata);

        if (pmem_read || pmem_write) begin
            if (!mbusy) begin
                mbusy = 1'b1;
                mlat  = $urandom_range(0, 3);
            end
            if (mlat == 0) begin
                if (!mem_hold) begin
                    pmem_resp = 1'b1;
                    if (pmem_read)  pmem_rdata = mem_rd(pmem_address);
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    mbusy = 1'b0;
                end
            end else begin
                mlat--;
            end
        end
        #1;

        check("i_resp", LW'(i_resp), LW'(m_owner == 1 && pmem_resp));
        check("d_resp", LW'(d_resp), LW'(m_owner == 2 && pmem_resp));
        if (i_resp) begin
            i_done = 1'b1;
            served_q.push_back(1);
            last_i_data = i_rdata;
            check("i_rdata", i_rdata, ref_rd(i_address));
            check("i_starve", LW'(i_wait <= 1), LW'(1));
            i_wait = 0;
            if (d_read || d_write) d_wait++;
        end
        if (d_resp) begin
            d_done = 1'b1;
            served_q.push_back(2);
            if (d_read) check("d_rdata", d_rdata, ref_rd(d_address));
            if (d_write) ref_mem[d_address] = d_wdata;
            check("d_starve", LW'(d_wait <= 1), LW'(1));
            d_wait = 0;
            if (i_read) i_wait++;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        mbusy     = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        i_wait    = 0;
        d_wait    = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", LW'(grant), '0);
        check("rst_pmem_read", LW'(pmem_read), '0);
        check("rst_pmem_write", LW'(pmem_write), '0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_owner = 0;
        m_last  = 2;
    endtask

    task automatic drain(input int max);
        for (int n = 0; n < max && (i_read || d_read || d_write); n++) step();
        check("drain", LW'({i_read, d_read, d_write}), '0);
    endtask

    localparam logic [LW-1:0] BeefLine = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;

    initial begin
        i_address = '0;
        d_address = '0;
        d_wdata   = '0;
        pmem_rdata = '0;
        auto_i = 1'b0;
        auto_d = 1'b0;
        prob_i = 0;
        prob_d = 0;
        mem_hold = 1'b0;
        mlat = 0;
        do_reset();

        // Single I read.
        i_read = 1'b1;
        i_address = 16'h0040;
        step();
        check("t1_grant", LW'(grant), LW'(2'b01));
        check("t1_addr", LW'(pmem_address), LW'(16'h0040));
        drain(50);
        check("t1_rdata", last_i_data, {8{16'h0040}});
        check("t1_grant_after", LW'(grant), '0);

        // D writeback then I read of the same line.
        d_write = 1'b1;
        d_address = 16'h1230;
        d_wdata = BeefLine;
        drain(50);
        i_read = 1'b1;
        i_address = 16'h1230;
        drain(50);
        check("t2_rdata", last_i_data, BeefLine);

        // Simultaneous requests right after reset: I first.
        do_reset();
        served_q.delete();
        i_read = 1'b1;
        i_address = 16'h0100;
        d_read = 1'b1;
        d_address = 16'h0200;
        drain(50);
        check("t3_count", LW'(served_q.size()), LW'(2));
        if (served_q.size() == 2) begin
            check("t3_first", LW'(served_q[0]), LW'(1));
            check("t3_second", LW'(served_q[1]), LW'(2));
        end

        // Continuous contention: strict alternation.
        served_q.delete();
        auto_i = 1'b1;
        auto_d = 1'b1;
        prob_i = 100;
        prob_d = 100;
        for (int n = 0; n < 300 && served_q.size() < 6; n++) step();
        auto_i = 1'b0;
        auto_d = 1'b0;
        drain(50);
        check("t4_count", LW'(served_q.size() >= 6), LW'(1));
        for (int k = 1; k < served_q.size(); k++)
            check("t4_alternate", LW'(served_q[k]), LW'(3 - served_q[k-1]));

        // D arrives while I is in service.
        served_q.delete();
        mem_hold = 1'b1;
        i_read = 1'b1;
        i_address = 16'h0300;
        step();
        step();
        d_read = 1'b1;
        d_address = 16'h0440;
        step();
        mem_hold = 1'b0;
        drain(50);
        check("t5_count", LW'(served_q.size()), LW'(2));
        if (served_q.size() == 2) begin
            check("t5_first", LW'(served_q[0]), LW'(1));
            check("t5_second", LW'(served_q[1]), LW'(2));
        end

        // Asynchronous reset during a D grant.
        mem_hold = 1'b1;
        d_read = 1'b1;
        d_address = 16'h0550;
        step();
        step();
        check("t6_pre_grant", LW'(grant), LW'(2'b10));
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_grant", LW'(grant), '0);
        check("t6_async_read", LW'(pmem_read), '0);
        check("t6_async_write", LW'(pmem_write), '0);
        check("t6_async_dresp", LW'(d_resp), '0);
        do_reset();
        mem_hold = 1'b0;
        served_q.delete();
        i_read = 1'b1;
        i_address = 16'h0660;
        d_read = 1'b1;
        d_address = 16'h0770;
        step();
        check("t6_first_grant", LW'(grant), LW'(2'b01));
        drain(50);
        check("t6_count", LW'(served_q.size()), LW'(2));

        // Random traffic.
        auto_i = 1'b1;
        auto_d = 1'b1;
        prob_i = 40;
        prob_d = 40;
        repeat (1500) step();
        auto_i = 1'b0;
        auto_d = 1'b0;
        drain(100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
